// File: rtl/vector_sequencer_if.sv
// -----------------------------------------------------------------------------
// vector_sequencer_if
//   Bundle between the vector sequencer and the combinational block under test
//   plus the result/status signals seen by whoever launches the sweep.
//
//   start      : start request into the sequencer
//   y          : output of the block under test
//   vec        : input vector driven to the block under test
//   busy/done  : sweep in progress / sweep finished
//   pass       : finished with zero mismatches
//   err_count  : number of mismatching vectors (N+1 bits)
//   fail_seen  : at least one mismatch since the last start
//   first_fail : index of the first mismatching vector
//
//   master : the sequencer side
//   slave  : the stimulus/observer side (DUT wrapper or testbench)
// -----------------------------------------------------------------------------
interface vector_sequencer_if #(
  parameter int N = 3
);
  logic         start;
  logic         y;
  logic [N-1:0] vec;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic         fail_seen;
  logic [N-1:0] first_fail;

  modport master (
    input  start, y,
    output vec, busy, done, pass, err_count, fail_seen, first_fail
  );

  modport slave (
    output start, y,
    input  vec, busy, done, pass, err_count, fail_seen, first_fail
  );
endinterface

// File: rtl/vector_sequencer.sv
// -----------------------------------------------------------------------------
// vector_sequencer
//   Exhaustive stimulus controller for a small combinational block. On start
//   it walks vec through all 2^N input vectors, holds each for SETTLE cycles,
//   samples y in a one-cycle CHECK state and compares it against the truth
//   table EXPECT (bit i = expected y for vector i). Reports pass/fail, an
//   error count and the first failing vector. All outputs are registered.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : vector_sequencer_if.master (start, y in; vec, status out)
//
//   Parameters:
//     N      : number of DUT inputs (must match the interface's N)
//     SETTLE : cycles each vector is held before sampling, 1..15
//     EXPECT : expected-output truth table, 2^N bits
//
//   Optional feature (macro VECSEQ_LOOP_EN):
//     When defined, start=1 during the last CHECK wraps into another pass
//     instead of entering DONE; done pulses for one cycle per wrap and
//     err_count accumulates (saturating) across passes.
// -----------------------------------------------------------------------------
module vector_sequencer #(
  parameter int                   N      = 3,
  parameter int                   SETTLE = 1,
  parameter logic [(1<<N)-1:0]    EXPECT = 8'h31
) (
  input  logic           clk,
  input  logic           reset,
  vector_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_e;

  localparam logic [N-1:0] LAST_IDX = '1;
  localparam logic [3:0]   CNT_LAST = 4'(SETTLE - 1);
  localparam logic [N:0]   ERR_MAX  = '1;

  state_e       state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N:0]   err_count_q, err_count_d;
  logic         fail_seen_q, fail_seen_d;
  logic [N-1:0] first_fail_q, first_fail_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;

  logic mismatch;
  logic last_vec;
  logic wrap;

  assign mismatch = bus.y != EXPECT[idx_q];
  assign last_vec = idx_q == LAST_IDX;

`ifdef VECSEQ_LOOP_EN
  // Continue into another pass when start is still requested at the last vector.
  assign wrap = (state_q == S_CHECK) && last_vec && bus.start;
`else
  assign wrap = 1'b0;
`endif

  // State register and all datapath/output flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_count_q  <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_count_q  <= err_count_d;
      fail_seen_q  <= fail_seen_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_DONE:  if (bus.start)          state_d = S_DRIVE;
      S_DRIVE: if (cnt_q == CNT_LAST)  state_d = S_CHECK;
      S_CHECK: state_d = (last_vec && !wrap) ? S_DONE : S_DRIVE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_count_d  = err_count_q;
    fail_seen_d  = fail_seen_q;
    first_fail_d = first_fail_q;

    unique case (state_q)
      S_IDLE,
      S_DONE: begin
        if (bus.start) begin
          idx_d        = '0;
          cnt_d        = '0;
          err_count_d  = '0;
          fail_seen_d  = 1'b0;
          first_fail_d = '0;
        end
      end
      S_DRIVE: cnt_d = cnt_q + 4'd1;
      S_CHECK: begin
        if (mismatch) begin
          // Saturation only matters when passes accumulate in loop mode.
          err_count_d = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + 1'b1;
          fail_seen_d = 1'b1;
          if (!fail_seen_q) first_fail_d = idx_q;
        end
        cnt_d = '0;
        // The index naturally rolls over to 0 on a wrap; in DONE it holds the
        // last vector on vec.
        idx_d = (last_vec && !wrap) ? idx_q : idx_q + 1'b1;
      end
      default: ;
    endcase

    // Status flops are loaded from the next state so they line up with it.
    busy_d = (state_d == S_DRIVE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE) || wrap;
    pass_d = done_d && (err_count_d == '0);
  end

  assign bus.vec        = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_count_q;
  assign bus.fail_seen  = fail_seen_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_sequencer
//   Bench for vector_sequencer with default parameters. A behavioural
//   sillyfunction model (optionally corrupted) drives y from vec. Each sweep
//   pushes its expected vec sequence and final results to queues; a negedge
//   monitor pops and compares them as the DUT produces them. With
//   VECSEQ_LOOP_EN defined a second instance (SETTLE=3) exercises looping.
// -----------------------------------------------------------------------------
module tb_vector_sequencer;

  typedef struct {
    int   err;
    int   first;
    logic fs;
    logic ps;
    int   cyc;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   mode;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_done = 1'b0;

  logic [2:0] exp_vec[$];
  res_t       exp_res[$];

  vector_sequencer_if #(.N(3)) bus ();

  vector_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference block: y = ~b&~c | a&~b with {a,b,c} = v.
  function automatic logic silly(input logic [2:0] v);
    return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
  endfunction

  // 0 correct, 1 stuck at 0, 2 inverted, 3 bit flip at vector 6 only.
  function automatic logic model_y(input logic [2:0] v, input int m);
    case (m)
      1:       return 1'b0;
      2:       return ~silly(v);
      3:       return silly(v) ^ (v == 3'd6);
      default: return silly(v);
    endcase
  endfunction

  assign bus.y = model_y(bus.vec, mode);

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Launch one sweep with model mode m and queue everything it should produce.
  task automatic sweep(input int m);
    res_t r;
    @(negedge clk);
    mode      = m;
    bus.start = 1'b1;
    r.err = 0; r.first = 0; r.fs = 1'b0;
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 2; k++) exp_vec.push_back(3'(v));
      if (model_y(3'(v), m) != silly(3'(v))) begin
        if (!r.fs) r.first = v;
        r.fs = 1'b1;
        r.err++;
      end
    end
    r.ps  = (r.err == 0);
    r.cyc = cyc + 17;
    exp_res.push_back(r);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_done", bus.done, 0);
    check("start_err_clr", bus.err_count, 0);
    check("start_fs_clr", bus.fail_seen, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.busy) begin
        if (exp_vec.size() == 0) check("vec_unexpected", 1, 0);
        else check("vec", bus.vec, exp_vec.pop_front());
      end
      if (bus.done && !prev_done) begin
        if (exp_res.size() == 0) check("done_unexpected", 1, 0);
        else begin
          res_t r;
          r = exp_res.pop_front();
          check("done_cycle", cyc, r.cyc);
          check("vec_left", exp_vec.size(), 0);
          check("err_count", bus.err_count, r.err);
          check("fail_seen", bus.fail_seen, r.fs);
          check("pass", bus.pass, r.ps);
          check("busy_in_done", bus.busy, 0);
          check("vec_last", bus.vec, 7);
          if (r.fs) check("first_fail", bus.first_fail, r.first);
        end
      end
    end
    prev_done <= bus.done;
  end

`ifdef VECSEQ_LOOP_EN
  vector_sequencer_if #(.N(3)) bus2 ();
  assign bus2.y = 1'b0;

  vector_sequencer #(.SETTLE(3)) dut_loop (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );
`endif

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    mode      = 0;
`ifdef VECSEQ_LOOP_EN
    bus2.start = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_vec", bus.vec, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_err", bus.err_count, 0);
    check("rst_fs", bus.fail_seen, 0);
    check("rst_ff", bus.first_fail, 0);
    reset = 1'b0;

    // Correct model, stuck-at-0, inverted, single flip at vector 6.
    for (int m = 0; m < 4; m++) begin
      sweep(m);
      wait_done();
    end

    // Re-pulse start early in a sweep: must be ignored.
    sweep(0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Asynchronous reset in DRIVE of vector 3 during a failing sweep.
    sweep(1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy && bus.vec == 3'd3) break;
    end
    check("pre_rst_fs", bus.fail_seen, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_vec", bus.vec, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_pass", bus.pass, 0);
    check("arst_err", bus.err_count, 0);
    check("arst_fs", bus.fail_seen, 0);
    check("arst_ff", bus.first_fail, 0);
    exp_vec.delete();
    exp_res.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);

    // Clean sweep after reset.
    sweep(0);
    wait_done();
    repeat (2) @(negedge clk);

`ifdef VECSEQ_LOOP_EN
    begin
      int k;
      @(negedge clk);
      bus2.start = 1'b1;
      k = cyc;
      for (int p = 1; p <= 3; p++) begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus2.done) break;
        end
        check("loop_done_cycle", cyc, k + 1 + 32 * p);
        check("loop_err", bus2.err_count, 3 * p);
        check("loop_ff", bus2.first_fail, 0);
        @(negedge clk);
        check("loop_pulse", bus2.done, 0);
        check("loop_busy", bus2.busy, 1);
      end
      bus2.start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus2.done) break;
      end
      check("loop_end_cycle", cyc, k + 1 + 128);
      check("loop_end_err", bus2.err_count, 12);
      repeat (2) @(negedge clk);
      check("loop_end_done", bus2.done, 1);
      check("loop_end_busy", bus2.busy, 0);
      check("loop_end_pass", bus2.pass, 0);
    end
`endif

    check("res_left", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
